// File: rtl/ii_port_arbiter.sv
// Port-A arbiter for the integral image buffer: capture writes, classifier and debug reads.
// Optional starvation monitor is built when II_ARB_STARVE_EN is defined.
module ii_port_arbiter #(
    parameter int unsigned ADDR_W       = 15,
    parameter int unsigned DATA_W       = 20,
    parameter int unsigned RD_LATENCY   = 2,
    parameter int unsigned STARVE_LIMIT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              cls_req,
    input  logic [ADDR_W-1:0] cls_addr,
    output logic              cls_gnt,
    output logic              cls_rvalid,
    output logic [DATA_W-1:0] cls_rdata,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              bram_we,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              starve
);

    localparam logic [0:0] OWNER_CLS = 1'b0;
    localparam logic [0:0] OWNER_DBG = 1'b1;
    // One {cls, dbg} pair per stage; the top pair lines up with valid bram_dout.
    localparam int unsigned TAG_W = 2 * (RD_LATENCY + 1);

    logic [0:0]        last_owner_q, last_owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              we_q, we_d;
    logic [TAG_W-1:0]  tag_q, tag_d;

    // Write always wins; readers share the remaining slot round-robin.
    always_comb begin
        cls_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (rst && !wr_req) begin
            if (cls_req && (!dbg_req || last_owner_q == OWNER_DBG)) begin
                cls_gnt = 1'b1;
            end else if (dbg_req) begin
                dbg_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        last_owner_d = last_owner_q;
        addr_d       = addr_q;
        din_d        = din_q;
        we_d         = 1'b0;
        tag_d        = {tag_q[TAG_W-3:0], cls_gnt, dbg_gnt};
        if (wr_req) begin
            addr_d = wr_addr;
            din_d  = wr_data;
            we_d   = 1'b1;
        end else if (cls_gnt) begin
            addr_d       = cls_addr;
            last_owner_d = OWNER_CLS;
        end else if (dbg_gnt) begin
            addr_d       = dbg_addr;
            last_owner_d = OWNER_DBG;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner_q <= OWNER_DBG;
            addr_q       <= '0;
            din_q        <= '0;
            we_q         <= 1'b0;
            tag_q        <= '0;
        end else begin
            last_owner_q <= last_owner_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            we_q         <= we_d;
            tag_q        <= tag_d;
        end
    end

    assign bram_addr  = addr_q;
    assign bram_din   = din_q;
    assign bram_we    = we_q;
    assign cls_rvalid = tag_q[TAG_W-1];
    assign dbg_rvalid = tag_q[TAG_W-2];
    assign cls_rdata  = bram_dout;
    assign dbg_rdata  = bram_dout;

`ifdef II_ARB_STARVE_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cls_cnt_q, cls_cnt_d;
    logic [CNT_W-1:0] dbg_cnt_q, dbg_cnt_d;
    logic             starve_q, starve_d;

    // Counts consecutive denied cycles; saturates so a long stall cannot wrap.
    function automatic logic [CNT_W-1:0] cnt_next(input logic             req,
                                                  input logic             gnt,
                                                  input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] nxt;
        nxt = cnt;
        if (!req || gnt) begin
            nxt = '0;
        end else if (cnt != CNT_MAX) begin
            nxt = cnt + CNT_W'(1);
        end
        return nxt;
    endfunction

    always_comb begin
        cls_cnt_d = cnt_next(cls_req, cls_gnt, cls_cnt_q);
        dbg_cnt_d = cnt_next(dbg_req, dbg_gnt, dbg_cnt_q);
        starve_d  = starve_q || (cls_cnt_d == CNT_MAX) || (dbg_cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cls_cnt_q <= '0;
            dbg_cnt_q <= '0;
            starve_q  <= 1'b0;
        end else begin
            cls_cnt_q <= cls_cnt_d;
            dbg_cnt_q <= dbg_cnt_d;
            starve_q  <= starve_d;
        end
    end

    assign starve = starve_q;
`else
    // STARVE_LIMIT only matters when the monitor is built in.
    logic unused_starve_limit;
    assign unused_starve_limit = ^32'(STARVE_LIMIT);
    assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_ii_port_arbiter.sv
// Directed bench for ii_port_arbiter with a two-cycle BRAM read model.
module tb_ii_port_arbiter;

    localparam int unsigned ADDR_W       = 15;
    localparam int unsigned DATA_W       = 20;
    localparam int unsigned RD_LATENCY   = 2;
    localparam int unsigned STARVE_LIMIT = 8;
`ifdef II_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              cls_req;
    logic [ADDR_W-1:0] cls_addr;
    logic              cls_gnt;
    logic              cls_rvalid;
    logic [DATA_W-1:0] cls_rdata;
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic              bram_we;
    logic [DATA_W-1:0] bram_dout;
    logic              starve;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ii_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .RD_LATENCY   (RD_LATENCY),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cls_req    (cls_req),
        .cls_addr   (cls_addr),
        .cls_gnt    (cls_gnt),
        .cls_rvalid (cls_rvalid),
        .cls_rdata  (cls_rdata),
        .dbg_req    (dbg_req),
        .dbg_addr   (dbg_addr),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .bram_we    (bram_we),
        .bram_dout  (bram_dout),
        .starve     (starve)
    );

    // BRAM model: address registered by the DUT, dout two edges later.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_pipe;
    always @(posedge clk) begin
        if (bram_we) mem[bram_addr] <= bram_din;
        rd_pipe   <= mem[bram_addr];
        bram_dout <= rd_pipe;
    end

    typedef struct {
        logic              wr_req;
        logic [ADDR_W-1:0] wr_addr;
        logic [DATA_W-1:0] wr_data;
        logic              cls_req;
        logic [ADDR_W-1:0] cls_addr;
        logic              dbg_req;
        logic [ADDR_W-1:0] dbg_addr;
        logic              cls_gnt;
        logic              dbg_gnt;
        logic              bram_we;
        logic [ADDR_W-1:0] bram_addr;
        logic [DATA_W-1:0] bram_din;
        logic              cls_rvalid;
        logic              dbg_rvalid;
        logic [DATA_W-1:0] rdata;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(input logic w, input int wa, input int wd,
                                input logic c, input int ca, input logic d, input int da,
                                input logic gc, input logic gd, input logic we,
                                input int ba, input int bd,
                                input logic cv, input logic dv, input int rd);
        vec_t v;
        v.wr_req = w;   v.wr_addr = ADDR_W'(wa); v.wr_data = DATA_W'(wd);
        v.cls_req = c;  v.cls_addr = ADDR_W'(ca);
        v.dbg_req = d;  v.dbg_addr = ADDR_W'(da);
        v.cls_gnt = gc; v.dbg_gnt = gd; v.bram_we = we;
        v.bram_addr = ADDR_W'(ba); v.bram_din = DATA_W'(bd);
        v.cls_rvalid = cv; v.dbg_rvalid = dv; v.rdata = DATA_W'(rd);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input int wa, input int wd,
                         input logic c, input int ca, input logic d, input int da);
        wr_req = w;   wr_addr = ADDR_W'(wa); wr_data = DATA_W'(wd);
        cls_req = c;  cls_addr = ADDR_W'(ca);
        dbg_req = d;  dbg_addr = ADDR_W'(da);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= DATA_W'(i + 1000);
        mem[9599] <= DATA_W'(5000);

        // Columns: wr(req,addr,data) cls(req,addr) dbg(req,addr) | gnt c/d, bram we/addr/din, rvalid c/d, rdata
        vecs[0]  = mk(0,0,0, 1,9599, 0,0,  1,0, 0,3,7,    0,0,0);
        vecs[1]  = mk(0,0,0, 0,0,    0,0,  0,0, 0,9599,7, 0,0,0);
        vecs[2]  = mk(0,0,0, 0,0,    0,0,  0,0, 0,9599,7, 0,0,0);
        vecs[3]  = mk(0,0,0, 0,0,    0,0,  0,0, 0,9599,7, 1,0,5000);
        vecs[4]  = mk(0,0,0, 0,0,    1,20, 0,1, 0,9599,7, 0,0,0);
        vecs[5]  = mk(0,0,0, 1,10,   1,20, 1,0, 0,20,7,   0,0,0);
        vecs[6]  = mk(0,0,0, 1,11,   1,20, 0,1, 0,10,7,   0,0,0);
        vecs[7]  = mk(0,0,0, 1,11,   1,21, 1,0, 0,20,7,   0,1,1020);
        vecs[8]  = mk(0,0,0, 1,12,   1,21, 0,1, 0,11,7,   1,0,1010);
        vecs[9]  = mk(0,0,0, 1,12,   0,0,  1,0, 0,21,7,   0,1,1020);
        vecs[10] = mk(1,1,5, 1,13,   0,0,  0,0, 0,12,7,   1,0,1011);
        vecs[11] = mk(0,0,0, 1,13,   0,0,  1,0, 1,1,5,    0,1,1021);
        vecs[12] = mk(1,2,9, 0,0,    0,0,  0,0, 0,13,5,   1,0,1012);
        vecs[13] = mk(0,0,0, 0,0,    0,0,  0,0, 1,2,9,    0,0,0);
        vecs[14] = mk(0,0,0, 1,1,    0,0,  1,0, 0,2,9,    1,0,1013);
        vecs[15] = mk(0,0,0, 0,0,    0,0,  0,0, 0,1,9,    0,0,0);
        vecs[16] = mk(0,0,0, 0,0,    0,0,  0,0, 0,1,9,    0,0,0);
        vecs[17] = mk(0,0,0, 0,0,    0,0,  0,0, 0,1,9,    1,0,5);
        vecs[18] = mk(0,0,0, 0,0,    0,0,  0,0, 0,1,9,    0,0,0);

        // Reset held with every requester active
        rst = 1'b0;
        drive(1, 3, 7, 1, 5, 1, 6);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst cls_gnt", 32'(cls_gnt), 0);
        chk("rst dbg_gnt", 32'(dbg_gnt), 0);
        chk("rst cls_rvalid", 32'(cls_rvalid), 0);
        chk("rst dbg_rvalid", 32'(dbg_rvalid), 0);
        chk("rst bram_we", 32'(bram_we), 0);
        chk("rst bram_addr", 32'(bram_addr), 0);
        chk("rst bram_din", 32'(bram_din), 0);
        chk("rst starve", 32'(starve), 0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("rel cls_gnt", 32'(cls_gnt), 0);
        chk("rel dbg_gnt", 32'(dbg_gnt), 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rel bram_we", 32'(bram_we), 1);
        chk("rel bram_addr", 32'(bram_addr), 3);
        chk("rel bram_din", 32'(bram_din), 7);
        next_cycle();

        // Table: lone reads, contention, write priority, write-after-read
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].wr_req, int'(vecs[i].wr_addr), int'(vecs[i].wr_data),
                  vecs[i].cls_req, int'(vecs[i].cls_addr), vecs[i].dbg_req, int'(vecs[i].dbg_addr));
            @(negedge clk);
            chk($sformatf("v%0d cls_gnt", i), 32'(cls_gnt), 32'(vecs[i].cls_gnt));
            chk($sformatf("v%0d dbg_gnt", i), 32'(dbg_gnt), 32'(vecs[i].dbg_gnt));
            chk($sformatf("v%0d bram_we", i), 32'(bram_we), 32'(vecs[i].bram_we));
            chk($sformatf("v%0d bram_addr", i), 32'(bram_addr), 32'(vecs[i].bram_addr));
            chk($sformatf("v%0d bram_din", i), 32'(bram_din), 32'(vecs[i].bram_din));
            chk($sformatf("v%0d cls_rvalid", i), 32'(cls_rvalid), 32'(vecs[i].cls_rvalid));
            chk($sformatf("v%0d dbg_rvalid", i), 32'(dbg_rvalid), 32'(vecs[i].dbg_rvalid));
            if (vecs[i].cls_rvalid) chk($sformatf("v%0d cls_rdata", i), 32'(cls_rdata), 32'(vecs[i].rdata));
            if (vecs[i].dbg_rvalid) chk($sformatf("v%0d dbg_rdata", i), 32'(dbg_rdata), 32'(vecs[i].rdata));
            chk($sformatf("v%0d starve", i), 32'(starve), 0);
            next_cycle();
        end

        // Three-way request held 10 cycles: write served, both readers stall
        for (int k = 1; k <= 10; k++) begin
            drive(1, 500, k, 1, 30, 1, 31);
            @(negedge clk);
            chk($sformatf("s%0d cls_gnt", k), 32'(cls_gnt), 0);
            chk($sformatf("s%0d dbg_gnt", k), 32'(dbg_gnt), 0);
            chk($sformatf("s%0d starve", k), 32'(starve), 32'(STARVE_ON && k >= 9));
            next_cycle();
        end
        drive(0, 0, 0, 1, 30, 1, 31);
        @(negedge clk);
        chk("s11 dbg_gnt", 32'(dbg_gnt), 1);
        chk("s11 cls_gnt", 32'(cls_gnt), 0);
        next_cycle();
        drive(0, 0, 0, 1, 30, 0, 0);
        @(negedge clk);
        chk("s12 cls_gnt", 32'(cls_gnt), 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int k = 13; k <= 16; k++) begin
            @(negedge clk);
            chk($sformatf("s%0d dbg_rvalid", k), 32'(dbg_rvalid), 32'(k == 14));
            chk($sformatf("s%0d cls_rvalid", k), 32'(cls_rvalid), 32'(k == 15));
            if (k == 14) chk("s14 dbg_rdata", 32'(dbg_rdata), 1031);
            if (k == 15) chk("s15 cls_rdata", 32'(cls_rdata), 1030);
            chk($sformatf("s%0d starve sticky", k), 32'(starve), 32'(STARVE_ON));
            next_cycle();
        end

        // Reset one cycle after a classifier accept
        drive(0, 0, 0, 1, 40, 0, 0);
        @(negedge clk);
        chk("r0 cls_gnt", 32'(cls_gnt), 1);
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            chk($sformatf("r%0d cls_rvalid", k), 32'(cls_rvalid), 0);
            chk($sformatf("r%0d starve", k), 32'(starve), 0);
            chk($sformatf("r%0d bram_we", k), 32'(bram_we), 0);
            next_cycle();
        end
        rst = 1'b1;
        for (int k = 3; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("r%0d cls_rvalid", k), 32'(cls_rvalid), 0);
            chk($sformatf("r%0d dbg_rvalid", k), 32'(dbg_rvalid), 0);
            next_cycle();
        end
        // last_owner back to dbg: classifier wins the first tie
        drive(0, 0, 0, 1, 50, 1, 51);
        @(negedge clk);
        chk("r9 cls_gnt", 32'(cls_gnt), 1);
        chk("r9 dbg_gnt", 32'(dbg_gnt), 0);
        chk("r9 starve", 32'(starve), 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ii_port_arbiter.md
# ii_port_arbiter

Arbiter for the single read/write port A of the integral image buffer (20-bit words, 15-bit address). It shares the port between three requesters: the capture path (writes, never stalled), the classifier (reads) and a debug readout (reads). It registers the chosen access onto the BRAM port and returns read data to the owning requester with a valid strobe aligned to BRAM latency. Sits between integral_image_capture / classifier / debug readout and integral_image_buffer, in the pixel-clock domain.

## Interface
- ADDR_W, 15, buffer address width
- DATA_W, 20, buffer word width
- RD_LATENCY, 2, BRAM cycles from registered address to valid dout (≥1)
- STARVE_LIMIT, 1024, consecutive denied-request cycles before starvation flag
- clk  in  1  pixel clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- wr_req  in  1  capture write request; always accepted
- wr_addr  in  ADDR_W  capture write address
- wr_data  in  DATA_W  capture write data
- cls_req  in  1  classifier read request
- cls_addr  in  ADDR_W  classifier read address
- cls_gnt  out  1  classifier request accepted this cycle
- cls_rvalid  out  1  cls_rdata valid
- cls_rdata  out  DATA_W  read data to classifier
- dbg_req / dbg_addr / dbg_gnt / dbg_rvalid / dbg_rdata: same as cls_*, for the debug reader
- bram_addr  out  ADDR_W  registered port-A address
- bram_din  out  DATA_W  registered port-A write data
- bram_we  out  1  registered port-A write enable
- bram_dout  in  DATA_W  port-A read data
- starve  out  1  sticky: a reader exceeded STARVE_LIMIT

## Operation
- Per-cycle priority: wr_req wins unconditionally. With wr_req high, cls_gnt and dbg_gnt are both 0.
- With no write, cls_req and dbg_req are round-robin arbitrated via a last_owner register. After reset last_owner = dbg, so the classifier wins the first tie.
- A lone read request is granted immediately.
- Grants are combinational from req, wr_req and last_owner. A request is accepted in any cycle with req & gnt. Requesters hold req/addr until they see gnt.
- On accept, on the next edge:
  - bram_addr ← accepted address
  - bram_we ← 1 for a write, 0 for a read
  - bram_din ← wr_data for a write, else held
- Idle cycle: bram_we ← 0, bram_addr holds.
- Read tag pipeline: depth RD_LATENCY+1, 2-bit tag {cls, dbg}.
  - cls_rdata and dbg_rdata both mirror bram_dout.
  - rvalid is asserted only for the tagged owner.
- Starvation monitor: per-reader counter, 0..STARVE_LIMIT, saturating.
  - Increments each cycle req & !gnt; clears on accept or when req drops.
  - Reaching STARVE_LIMIT sets starve. starve clears only on reset.

## Timing
- Reset values: cls_gnt/dbg_gnt follow inputs combinationally (0 while rst low); cls_rvalid=dbg_rvalid=0, bram_we=0, bram_addr=0, bram_din=0, starve=0, tag pipeline cleared, last_owner=dbg.
- Write: accepted cycle t, bram_we=1 during t+1.
- Read: accepted cycle t, bram_addr presented t+1, rvalid high for exactly one cycle at t+1+RD_LATENCY.
- Throughput: one access per cycle. Back-to-back reads from either reader pipeline with no bubbles.
- Write-after-read: a write in the cycle after a read accept does not disturb the in-flight read; tags are independent of bram_we.
- Simultaneous three-way request: write served; both readers stall and their starve counters increment.
- Reset asserted mid-operation: in-flight reads are discarded and no rvalid fires after reset release.

## Configuration
- II_ARB_STARVE_EN defined: starvation counters and the starve flag are implemented as above.
- II_ARB_STARVE_EN undefined: counters are omitted and starve is tied to 0.

## Test plan
- Reset: hold rst=0 with all requests high → gnts 0, all rvalid 0, bram_we 0. Release → cycle 1: write accepted, cls_gnt=dbg_gnt=0.
- Lone classifier read: cls_addr=9599, BRAM word 5000 → cls_gnt same cycle, bram_addr=9599 next cycle, cls_rvalid with cls_rdata=5000 at accept+3 (RD_LATENCY=2); dbg_rvalid stays 0.
- Contention: cls_req and dbg_req held 4 cycles, no write → grants alternate cls, dbg, cls, dbg; 4 rvalids in the same order, each 3 cycles after its accept.
- Write priority: wr_req at addr 1, data 5 simultaneous with cls_req → bram_we=1, bram_addr=1, bram_din=5 next cycle; cls granted the following cycle.
- Starvation (II_ARB_STARVE_EN, STARVE_LIMIT=8): wr_req high 10 cycles with dbg_req high → starve rises after 8 denied cycles and stays 1 after dbg is served. Macro undefined → starve stays 0.
- Reset mid-read: assert rst one cycle after a cls accept → no cls_rvalid pulse before or after release.
